f1_reaction_timer: RTL and testbench
====================================

Name: f1_reaction_timer

Overview:
- Consumer of the F1 start-light bus.
- Watches the 8-bit light pattern from the light sequencer and detects the all-on to all-off transition ("lights out").
- Measures the driver's button reaction time in milliseconds and flags jump starts and timeouts.
- Keeps a best (minimum) reaction time for display on the 7-segment/LED outputs.

Parameters:
- CYCLES_PER_MS, 1000, clk cycles per millisecond tick of the internal prescaler (min 2).
- MAX_MS, 9999, timeout limit in ms; must fit in 16 bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- lights  in  8  light pattern from the sequencer; same clock domain, sampled directly.
- btn  in  1  driver button, active-high, asynchronous; debounced externally.
- react_ms  out  16  last result in ms, held until the next result.
- valid  out  1  one-cycle pulse when react_ms updates.
- timeout  out  1  high when the last result was a timeout; cleared on the next valid result or jump.
- jump_start  out  1  level; set on a press before lights out; cleared when the next sequence starts.
- best_ms  out  16  minimum non-timeout react_ms since reset.
- state  out  3  debug state code.

Behaviour:
- Async reset clears the FSM, synchronizer and counters, and sets outputs to:
  - react_ms=0, valid=0, timeout=0, jump_start=0.
  - best_ms=16'hFFFF.
  - state=IDLE.
- Button path:
  - btn passes through a 2-flop synchronizer (s1, s2), then an edge register q.
  - press = s2 & ~q, one cycle per rising edge.
  - press asserts on the 3rd rising clk edge after btn is first sampled high.
  - Holding btn gives no further presses.
- States (code):
  - IDLE (0): lights!=0 -> SEQ; clear jump_start on that transition. Press ignored.
  - SEQ (1):
    - press -> JUMP (priority).
    - else lights==8'hFF -> ALL_ON.
    - else lights==0 -> IDLE (sequence aborted).
  - ALL_ON (2):
    - press -> JUMP (priority, including the cycle lights goes to 0).
    - else lights==0 -> TIMING, with pcnt<=0 and ms_cnt<=0.
    - else lights!=FF -> SEQ.
  - TIMING (3), per cycle:
    - If ms_cnt==MAX_MS -> RESULT with react_ms<=MAX_MS, timeout<=1. Press in that cycle is ignored.
    - Else if press -> RESULT with react_ms<=ms_cnt (pre-increment value), timeout<=0, best_ms<=min(best_ms, ms_cnt).
    - Else prescaler runs: if pcnt==CYCLES_PER_MS-1 then pcnt<=0, ms_cnt<=ms_cnt+1; else pcnt<=pcnt+1.
    - lights changes during TIMING are ignored.
  - RESULT (4): valid=1 for exactly this cycle -> IDLE unconditionally.
  - JUMP (5):
    - Entry sets jump_start<=1 and timeout<=0; react_ms and best_ms unchanged; no valid pulse.
    - lights==0 -> IDLE.
- Timing arithmetic:
  - For a press detected k cycles after TIMING entry (k=0 is the first TIMING cycle), react_ms = floor(k / CYCLES_PER_MS).
  - Timeout RESULT is entered at k = MAX_MS*CYCLES_PER_MS.
- All counters are unsigned. ms_cnt is 16-bit and never exceeds MAX_MS. pcnt is $clog2(CYCLES_PER_MS) bits.
- Reset mid-TIMING aborts with no valid pulse, and best_ms returns to FFFF.

Test Plan:
All scenarios use CYCLES_PER_MS=4, MAX_MS=20.
- Reset: assert rst mid-TIMING -> state=0, react_ms=0, best_ms=FFFF, valid=0, jump_start=0, with no valid pulse afterwards.
- Normal run: lights step 01,03..FF, then 00. Press detected at TIMING k=10 -> one valid pulse, react_ms=2, best_ms=2, timeout=0.
- Best tracking: run 1 has press at k=10 (react 2); run 2 has press at k=23 (react 5) -> best_ms stays 2. Run 3 has press at k=2 (react 0) -> best_ms=0.
- Jump start:
  - Press while lights=07 -> jump_start=1, state=5, no valid, react_ms unchanged.
  - lights 00 -> IDLE; next lights=01 clears jump_start.
  - A press in the same cycle lights goes FF->00 also gives a jump.
- Timeout: no press -> valid at k=80 with react_ms=20 and timeout=1; best_ms unchanged. A press in that cycle is ignored.
- Aborts and edges:
  - lights FF->07 in ALL_ON -> SEQ; lights 07->00 in SEQ -> IDLE; no valid in either case.
  - btn held high across TIMING entry produces no press.
  - A press at k=3 gives react_ms=0; a press at k=4 gives 1.

Source files
------------

// File: rtl/f1_reaction_timer_if.sv
// F1 start-light consumer bus: light pattern and button in, reaction results out.
interface f1_reaction_timer_if;
  logic [7:0]  lights;
  logic        btn;
  logic [15:0] react_ms;
  logic        valid;
  logic        timeout;
  logic        jump_start;
  logic [15:0] best_ms;
  logic [2:0]  state;

  modport master (
    output lights, btn,
    input  react_ms, valid, timeout, jump_start, best_ms, state
  );

  modport slave (
    input  lights, btn,
    output react_ms, valid, timeout, jump_start, best_ms, state
  );
endinterface

// File: rtl/f1_reaction_timer.sv
// Detects lights-out on the start-light bus, times the driver's button press in ms,
// flags jump starts and timeouts, and tracks the best reaction since reset.
module f1_reaction_timer #(
  parameter int unsigned CYCLES_PER_MS = 1000,
  parameter int unsigned MAX_MS        = 9999
) (
  input logic                clk,
  input logic                rst,
  f1_reaction_timer_if.slave bus
);

  localparam int unsigned PW = $clog2(CYCLES_PER_MS);
  localparam logic [PW-1:0] P_LAST = PW'(CYCLES_PER_MS - 1);
  localparam logic [15:0]   MS_MAX = 16'(MAX_MS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SEQ    = 3'd1;
  localparam logic [2:0] ALL_ON = 3'd2;
  localparam logic [2:0] TIMING = 3'd3;
  localparam logic [2:0] RESULT = 3'd4;
  localparam logic [2:0] JUMP   = 3'd5;

  logic [2:0]    state_q, state_nxt;
  logic          s1, s2, q;
  logic          press_c;
  logic [PW-1:0] pcnt;
  logic [15:0]   ms_cnt;
  logic [15:0]   react_q, best_q;
  logic          valid_q, timeout_q, jump_q;

  logic start_timing, run_timing, do_timeout, do_result, enter_jump, clr_jump;

  // Button synchronizer plus edge register; one press per rising edge of btn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= bus.btn;
      s2 <= s1;
      q  <= s2;
    end
  end

  assign press_c = s2 & ~q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state and datapath strobes; a press always wins over light changes.
  always_comb begin
    state_nxt    = state_q;
    start_timing = 1'b0;
    run_timing   = 1'b0;
    do_timeout   = 1'b0;
    do_result    = 1'b0;
    enter_jump   = 1'b0;
    clr_jump     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.lights != 8'h00) begin
          state_nxt = SEQ;
          clr_jump  = 1'b1;
        end
      end
      SEQ: begin
        if (press_c) begin
          state_nxt  = JUMP;
          enter_jump = 1'b1;
        end else if (bus.lights == 8'hFF) begin
          state_nxt = ALL_ON;
        end else if (bus.lights == 8'h00) begin
          state_nxt = IDLE;
        end
      end
      ALL_ON: begin
        if (press_c) begin
          state_nxt  = JUMP;
          enter_jump = 1'b1;
        end else if (bus.lights == 8'h00) begin
          state_nxt    = TIMING;
          start_timing = 1'b1;
        end else if (bus.lights != 8'hFF) begin
          state_nxt = SEQ;
        end
      end
      TIMING: begin
        if (ms_cnt == MS_MAX) begin
          state_nxt  = RESULT;
          do_timeout = 1'b1;
        end else if (press_c) begin
          state_nxt = RESULT;
          do_result = 1'b1;
        end else begin
          run_timing = 1'b1;
        end
      end
      RESULT: state_nxt = IDLE;
      JUMP: begin
        if (bus.lights == 8'h00) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Millisecond prescaler; ms_cnt saturates via the timeout exit before passing MAX_MS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt   <= '0;
      ms_cnt <= '0;
    end else if (start_timing) begin
      pcnt   <= '0;
      ms_cnt <= '0;
    end else if (run_timing) begin
      if (pcnt == P_LAST) begin
        pcnt   <= '0;
        ms_cnt <= ms_cnt + 16'd1;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  // Result registers; valid lines up with the single RESULT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      react_q   <= '0;
      best_q    <= 16'hFFFF;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      jump_q    <= 1'b0;
    end else begin
      valid_q <= (state_nxt == RESULT);
      if (do_timeout) begin
        react_q   <= MS_MAX;
        timeout_q <= 1'b1;
      end else if (do_result) begin
        react_q   <= ms_cnt;
        timeout_q <= 1'b0;
        if (ms_cnt < best_q) best_q <= ms_cnt;
      end
      if (enter_jump) begin
        jump_q    <= 1'b1;
        timeout_q <= 1'b0;
      end else if (clr_jump) begin
        jump_q <= 1'b0;
      end
    end
  end

  assign bus.react_ms   = react_q;
  assign bus.valid      = valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.jump_start = jump_q;
  assign bus.best_ms    = best_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Bench for f1_reaction_timer: directed races, a vector table and random races
// checked every cycle against a cycle-count reference model.
module tb_f1_reaction_timer;

  localparam int unsigned C = 4;
  localparam int unsigned M = 20;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  f1_reaction_timer_if bus();

  f1_reaction_timer #(.CYCLES_PER_MS(C), .MAX_MS(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase code, cycles since lights out, last three btn samples.
  int          m_ph;
  int          m_k;
  logic [15:0] m_react, m_best;
  logic        m_valid, m_to, m_jump;
  logic        p1, p2, p3;

  typedef struct {
    logic [7:0] lights;
    logic       btn;
    logic [2:0] state;
    logic       jump;
    logic       valid;
  } vec_t;

  vec_t tbl [13];

  task automatic model_reset();
    m_ph = 0; m_k = 0;
    m_react = 16'h0000; m_best = 16'hFFFF;
    m_valid = 1'b0; m_to = 1'b0; m_jump = 1'b0;
    p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] l, input logic b);
    logic press;
    int   r;
    // A press is seen once the btn was high two edges ago and low three edges ago.
    press = p2 & ~p3;
    case (m_ph)
      0: if (l != 8'h00) begin m_ph = 1; m_jump = 1'b0; end
      1: begin
        if (press) begin m_ph = 5; m_jump = 1'b1; m_to = 1'b0; end
        else if (l == 8'hFF) m_ph = 2;
        else if (l == 8'h00) m_ph = 0;
      end
      2: begin
        if (press) begin m_ph = 5; m_jump = 1'b1; m_to = 1'b0; end
        else if (l == 8'h00) begin m_ph = 3; m_k = 0; end
        else if (l != 8'hFF) m_ph = 1;
      end
      3: begin
        if (m_k == int'(M * C)) begin
          m_ph = 4; m_react = 16'(M); m_to = 1'b1;
        end else if (press) begin
          r = m_k / int'(C);
          m_ph = 4; m_react = 16'(r); m_to = 1'b0;
          if (r < int'(m_best)) m_best = 16'(r);
        end else begin
          m_k = m_k + 1;
        end
      end
      4: m_ph = 0;
      default: if (l == 8'h00) m_ph = 0;
    endcase
    m_valid = (m_ph == 4);
    p3 = p2; p2 = p1; p1 = b;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock with the given inputs; all outputs compared against the model.
  task automatic cyc(input logic [7:0] l, input logic b);
    bus.lights = l;
    bus.btn    = b;
    @(posedge clk);
    model_step(l, b);
    #1;
    chk("state",      32'(bus.state),      32'(m_ph));
    chk("react_ms",   32'(bus.react_ms),   32'(m_react));
    chk("best_ms",    32'(bus.best_ms),    32'(m_best));
    chk("valid",      32'(bus.valid),      32'(m_valid));
    chk("timeout",    32'(bus.timeout),    32'(m_to));
    chk("jump_start", 32'(bus.jump_start), 32'(m_jump));
  endtask

  // Full light sequence then lights out; btn rises at cycle kp-2 so the press lands at k=kp.
  task automatic race(input int kp, input logic held, input logic [15:0] e_react,
                      input logic [15:0] e_best, input logic e_to, input string nm);
    int   pulses;
    logic b;
    pulses = 0;
    b = held;
    if (held) repeat (3) cyc(8'h00, 1'b1);
    for (int i = 1; i <= 8; i++) cyc(8'((1 << i) - 1), b);
    cyc(8'h00, b);
    chk({nm, " entry"}, 32'(bus.state), 32'd3);
    for (int n = 0; n < 200; n++) begin
      b = held || (kp >= 0 && n >= kp - 2);
      cyc(8'h00, b);
      if (bus.valid) pulses++;
      if (bus.state == 3'd0) break;
    end
    chk({nm, " pulses"},  32'(pulses),       32'd1);
    chk({nm, " idle"},    32'(bus.state),    32'd0);
    chk({nm, " react"},   32'(bus.react_ms), 32'(e_react));
    chk({nm, " best"},    32'(bus.best_ms),  32'(e_best));
    chk({nm, " timeout"}, 32'(bus.timeout),  32'(e_to));
    repeat (3) cyc(8'h00, 1'b0);
  endtask

  initial begin
    int pulses;
    tbl[0]  = '{8'h01, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[1]  = '{8'h03, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[2]  = '{8'h07, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[3]  = '{8'h07, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[4]  = '{8'h07, 1'b1, 3'd5, 1'b1, 1'b0};
    tbl[5]  = '{8'h07, 1'b0, 3'd5, 1'b1, 1'b0};
    tbl[6]  = '{8'h00, 1'b0, 3'd0, 1'b1, 1'b0};
    tbl[7]  = '{8'h01, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[8]  = '{8'h03, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[9]  = '{8'hFF, 1'b0, 3'd2, 1'b0, 1'b0};
    tbl[10] = '{8'h07, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[11] = '{8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[12] = '{8'h00, 1'b0, 3'd0, 1'b0, 1'b0};

    rst = 1'b1;
    bus.lights = 8'h00;
    bus.btn    = 1'b0;
    model_reset();
    #12;
    chk("reset state",   32'(bus.state),      32'd0);
    chk("reset react",   32'(bus.react_ms),   32'd0);
    chk("reset best",    32'(bus.best_ms),    32'hFFFF);
    chk("reset valid",   32'(bus.valid),      32'd0);
    chk("reset timeout", 32'(bus.timeout),    32'd0);
    chk("reset jump",    32'(bus.jump_start), 32'd0);
    #10 rst = 1'b0;

    race(10, 1'b0, 16'd2,  16'd2, 1'b0, "normal");
    race(23, 1'b0, 16'd5,  16'd2, 1'b0, "best_keep");
    race(2,  1'b0, 16'd0,  16'd0, 1'b0, "best_new");
    race(80, 1'b0, 16'd20, 16'd0, 1'b1, "timeout_press");
    race(-1, 1'b1, 16'd20, 16'd0, 1'b1, "held");
    race(3,  1'b0, 16'd0,  16'd0, 1'b0, "k3");
    race(4,  1'b0, 16'd1,  16'd0, 1'b0, "k4");

    // Press landing on the same edge as FF->00 is still a jump start.
    for (int i = 1; i <= 6; i++) cyc(8'((1 << i) - 1), 1'b0);
    cyc(8'h7F, 1'b1);
    cyc(8'hFF, 1'b1);
    cyc(8'h00, 1'b1);
    chk("lo_jump state", 32'(bus.state),      32'd5);
    chk("lo_jump flag",  32'(bus.jump_start), 32'd1);
    chk("lo_jump valid", 32'(bus.valid),      32'd0);
    chk("lo_jump react", 32'(bus.react_ms),   32'd1);
    cyc(8'h00, 1'b0);
    chk("lo_jump idle",  32'(bus.state),      32'd0);

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].lights, tbl[i].btn);
      chk($sformatf("tbl%0d state", i), 32'(bus.state),      32'(tbl[i].state));
      chk($sformatf("tbl%0d jump", i),  32'(bus.jump_start), 32'(tbl[i].jump));
      chk($sformatf("tbl%0d valid", i), 32'(bus.valid),      32'(tbl[i].valid));
    end

    // Asynchronous reset in the middle of timing.
    for (int i = 1; i <= 8; i++) cyc(8'((1 << i) - 1), 1'b0);
    cyc(8'h00, 1'b0);
    repeat (5) cyc(8'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst state", 32'(bus.state),      32'd0);
    chk("midrst react", 32'(bus.react_ms),   32'd0);
    chk("midrst best",  32'(bus.best_ms),    32'hFFFF);
    chk("midrst valid", 32'(bus.valid),      32'd0);
    chk("midrst jump",  32'(bus.jump_start), 32'd0);
    model_reset();
    #2 rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 100; n++) begin
      cyc(8'h00, 1'b0);
      if (bus.valid) pulses++;
    end
    chk("midrst no valid", 32'(pulses), 32'd0);

    // Random races: jumps, light glitches, late/absent presses.
    for (int r = 0; r < 40; r++) begin
      int mode, kp, hold, dw;
      logic [7:0] l;
      mode = int'($urandom_range(0, 3));
      kp   = int'($urandom_range(0, 90));
      hold = int'($urandom_range(1, 6));
      repeat ($urandom_range(1, 3)) cyc(8'h00, 1'b0);
      for (int i = 1; i <= 8; i++) begin
        dw = int'($urandom_range(1, 2));
        for (int d = 0; d < dw; d++) begin
          l = 8'((1 << i) - 1);
          if (mode == 1 && $urandom_range(0, 9) == 0) l = 8'($urandom_range(0, 255));
          cyc(l, (mode == 0) && ($urandom_range(0, 5) == 0));
        end
      end
      for (int n = 0; n < 95; n++) begin
        l = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        cyc(l, (mode != 3) && n >= kp && n < kp + hold);
      end
    end
    repeat (3) cyc(8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
